// File: rtl/npu_pkg.sv
// Shared NPU constants: datapath width and output-format register field layout.
package npu_pkg;

  localparam int unsigned NPU_DATA_W            = 16;
  localparam int unsigned NPU_OUT_FMT_SHIFT_LSB = 0;
  localparam int unsigned NPU_OUT_FMT_SHIFT_W   = 4;
  localparam int unsigned NPU_OUT_FMT_SGN_BIT   = 4;

endpackage : npu_pkg

// File: rtl/npu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with explicit occupancy count.
// Head word reads as zero while empty; a push into a full FIFO is only taken alongside a pop.
module npu_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != FULL_CNT) | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observable through the count-guarded head.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule : npu_sync_fifo

// File: rtl/npu_output_interface.sv
// NPU output stage: formats 16-bit results into 32-bit host words through a one-cycle
// conversion register, then buffers them in a FWFT FIFO with a sticky drop flag.
module npu_output_interface
  import npu_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned DIN_W  = NPU_DATA_W,
  parameter int unsigned DOUT_W = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DIN_W-1:0]      npu_output_din,
  input  logic                  npu_output_fifo_write_en,
  input  logic [NPU_DATA_W-1:0] npu_config_data,
  input  logic                  npu_output_format_write_en,
  input  logic                  npu_output_fifo_read_en,
  output logic [DOUT_W-1:0]     npu_output_data,
  output logic                  npu_output_fifo_empty,
  output logic                  npu_output_fifo_full,
  output logic [ADDR_W:0]       npu_output_fifo_count,
  output logic                  npu_output_overflow
);

  logic [NPU_DATA_W-1:0]          fmt_q, fmt_d;
  logic [DOUT_W-1:0]              stage_data_q, stage_data_d;
  logic                           stage_vld_q, stage_vld_d;
  logic                           overflow_q, overflow_d;
  logic [NPU_OUT_FMT_SHIFT_W-1:0] fmt_shift;
  logic                           fmt_sgn;
  logic [DOUT_W-1:0]              ext_din;
  logic                           fifo_pop, fifo_push;

  assign fmt_shift = fmt_q[NPU_OUT_FMT_SHIFT_LSB +: NPU_OUT_FMT_SHIFT_W];
  assign fmt_sgn   = fmt_q[NPU_OUT_FMT_SGN_BIT];
  assign ext_din   = {{(DOUT_W-DIN_W){fmt_sgn & npu_output_din[DIN_W-1]}}, npu_output_din};

  // Conversion uses the format held before this edge; a same-edge format write affects later captures.
  always_comb begin
    fmt_d        = npu_output_format_write_en ? npu_config_data : fmt_q;
    stage_vld_d  = npu_output_fifo_write_en;
    stage_data_d = npu_output_fifo_write_en ? (ext_din << fmt_shift) : stage_data_q;
    fifo_pop     = npu_output_fifo_read_en & ~npu_output_fifo_empty;
    fifo_push    = stage_vld_q & (~npu_output_fifo_full | fifo_pop);
    overflow_d   = overflow_q | (stage_vld_q & ~fifo_push);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fmt_q        <= '0;
      stage_data_q <= '0;
      stage_vld_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      fmt_q        <= fmt_d;
      stage_data_q <= stage_data_d;
      stage_vld_q  <= stage_vld_d;
      overflow_q   <= overflow_d;
    end
  end

  npu_sync_fifo #(
    .WIDTH (DOUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (stage_data_q),
    .dout  (npu_output_data),
    .count (npu_output_fifo_count),
    .full  (npu_output_fifo_full),
    .empty (npu_output_fifo_empty)
  );

  assign npu_output_overflow = overflow_q;

endmodule : npu_output_interface
